// File: rtl/tester_pkg.sv
// Shared definitions for the chip-tester datapath: check-entry layout,
// stimulus-engine switch commands and the result checker state encoding.
package tester_pkg;

    localparam int CE_FLAGS_MSB = 51;
    localparam int CE_FLAGS_LSB = 48;
    localparam int CE_EXP_MSB   = 47;
    localparam int CE_EXP_LSB   = 24;
    localparam int CE_MASK_MSB  = 23;
    localparam int CE_MASK_LSB  = 0;

    // flags[0] marks an entry that is popped but produces no record
    localparam int CE_FLAG_DISCARD = CE_FLAGS_LSB;

    typedef enum logic [4:0] {
        SC_NOP      = 5'd0,
        SC_SET_RPTR = 5'd1
    } sc_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_HI = 2'd1,
        ST_WR_LO = 2'd2
    } rc_state_e;

endpackage

// File: rtl/result_check.sv
// Result checker: pairs each check entry with a captured response, compares
// under mask and writes a two-word pass/fail record to SRAM.
module result_check
    import tester_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR = 20'h80000,
    parameter int          VEC_W     = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [19:0]          mem_address,
    output logic [1:0]           mem_byteenable,
    output logic                 mem_write,
    output logic [15:0]          mem_writedata,
    input  logic                 mem_waitrequest,
    input  logic [VEC_W-1:0]     rfifo_data,
    output logic                 rfifo_rdreq,
    input  logic                 rfifo_rdempty,
    input  logic [2*VEC_W+3:0]   cfifo_data,
    output logic                 cfifo_rdreq,
    input  logic                 cfifo_rdempty,
    input  logic [4:0]           sc_cmd,
    input  logic [VEC_W-1:0]     sc_data,
    input  logic                 sc_switching,
    output logic                 sc_ready
);

    rc_state_e          state_reg, state_next;
    logic [19:0]        ptr_reg, ptr_next;
    logic [VEC_W-1:0]   actual_reg;
    logic               pass_reg;
    logic               sc_ready_reg;

    logic [VEC_W-1:0]   exp_field;
    logic [VEC_W-1:0]   mask_field;
    logic [VEC_W-1:0]   miss_bits;
    logic               pass_now;
    logic               take;
    logic               accepted;
    logic               unused_bits;

    assign exp_field  = cfifo_data[CE_EXP_MSB:CE_EXP_LSB];
    assign mask_field = cfifo_data[CE_MASK_MSB:CE_MASK_LSB];
    assign unused_bits = ^{cfifo_data[CE_FLAGS_MSB:CE_FLAGS_LSB+1], sc_data[VEC_W-1:20]};

    generate
        for (genvar gi = 0; gi < VEC_W; gi++) begin : g_cmp
            assign miss_bits[gi] = (rfifo_data[gi] ^ exp_field[gi]) & mask_field[gi];
        end
    endgenerate

    assign pass_now = ~|miss_bits;

    // Both FIFOs must hold an entry; they are always popped as a pair.
    assign take     = (state_reg == ST_IDLE) && !cfifo_rdempty && !rfifo_rdempty && !reset;
    assign accepted = !mem_waitrequest;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (take) begin
                    state_next = cfifo_data[CE_FLAG_DISCARD] ? ST_IDLE : ST_WR_HI;
                end
                if (sc_ready_reg && (sc_cmd == SC_SET_RPTR)) begin
                    ptr_next = sc_data[19:0];
                end
            end
            ST_WR_HI: begin
                if (accepted) begin
                    state_next = ST_WR_LO;
                end
            end
            ST_WR_LO: begin
                if (accepted) begin
                    state_next = ST_IDLE;
                    ptr_next   = ptr_reg + 20'd2;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= BASE_ADDR;
            actual_reg   <= '0;
            pass_reg     <= 1'b0;
            sc_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            if (take) begin
                actual_reg <= rfifo_data;
                pass_reg   <= pass_now;
            end
            sc_ready_reg <= sc_switching && (state_reg == ST_IDLE) && cfifo_rdempty;
        end
    end

    // Write port is decoded from the state so address and data stay frozen
    // for as long as the memory stalls.
    always_comb begin
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_reg)
            ST_WR_HI: begin
                mem_write     = 1'b1;
                mem_address   = ptr_reg;
                mem_writedata = {pass_reg, 7'b0, actual_reg[23:16]};
            end
            ST_WR_LO: begin
                mem_write     = 1'b1;
                mem_address   = ptr_reg + 20'd1;
                mem_writedata = actual_reg[15:0];
            end
            default: ;
        endcase
    end

    assign mem_byteenable = 2'b11;
    assign cfifo_rdreq    = take;
    assign rfifo_rdreq    = take;
    assign sc_ready       = sc_ready_reg;

endmodule

// File: tb/tb_result_check.sv
// Scoreboard bench for result_check: FIFO models feed the DUT, expected SRAM
// writes are queued at stimulus time and a monitor checks each accepted write.
module tb_result_check;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest;
    logic [23:0] rfifo_data;
    logic        rfifo_rdreq;
    logic        rfifo_rdempty;
    logic [51:0] cfifo_data;
    logic        cfifo_rdreq;
    logic        cfifo_rdempty;
    logic [4:0]  sc_cmd;
    logic [23:0] sc_data;
    logic        sc_switching;
    logic        sc_ready;

    always #5 clock = ~clock;

    result_check dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .rfifo_data     (rfifo_data),
        .rfifo_rdreq    (rfifo_rdreq),
        .rfifo_rdempty  (rfifo_rdempty),
        .cfifo_data     (cfifo_data),
        .cfifo_rdreq    (cfifo_rdreq),
        .cfifo_rdempty  (cfifo_rdempty),
        .sc_cmd         (sc_cmd),
        .sc_data        (sc_data),
        .sc_switching   (sc_switching),
        .sc_ready       (sc_ready)
    );

    logic [51:0] cq[$];
    logic [23:0] rq[$];
    logic [35:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cpops = 0;
    int rpops = 0;
    int acc_cnt = 0;
    int stall_cnt = 0;
    bit bp_en = 1'b0;
    bit force_wait = 1'b0;
    bit prev_stall = 1'b0;
    logic [19:0] prev_addr;
    logic [15:0] prev_data;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic push_vec(input logic [3:0] f, input logic [23:0] e, input logic [23:0] m,
                            input logic [23:0] a);
        cq.push_back({f, e, m});
        rq.push_back(a);
    endtask

    task automatic expect_rec(input logic [19:0] a, input logic [15:0] w0, input logic [15:0] w1);
        exp_q.push_back({a, w0});
        exp_q.push_back({a + 20'd1, w1});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || cq.size() != 0 || rq.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_in_time"}, 64'(n < 300), 64'd1);
        repeat (2) tick();
    endtask

    // FIFO model: pop on the edge where rdreq is seen
    always @(posedge clock) begin
        if (cfifo_rdreq && cq.size() > 0) begin
            void'(cq.pop_front());
            cpops++;
        end
        if (rfifo_rdreq && rq.size() > 0) begin
            void'(rq.pop_front());
            rpops++;
        end
    end

    // Drives FIFO heads and waitrequest shortly after each rising edge
    initial begin
        cfifo_rdempty   = 1'b1;
        cfifo_data      = '0;
        rfifo_rdempty   = 1'b1;
        rfifo_data      = '0;
        mem_waitrequest = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cfifo_rdempty = (cq.size() == 0);
            cfifo_data    = (cq.size() == 0) ? 52'd0 : cq[0];
            rfifo_rdempty = (rq.size() == 0);
            rfifo_data    = (rq.size() == 0) ? 24'd0 : rq[0];
            if (force_wait) begin
                mem_waitrequest = 1'b1;
            end else if (bp_en && mem_write && stall_cnt < 3) begin
                mem_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    // Monitor: pairs pops, stall stability and every accepted write
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_write", 64'(mem_write), 64'd1);
                chk("hold_addr", 64'(mem_address), 64'(prev_addr));
                chk("hold_data", 64'(mem_writedata), 64'(prev_data));
            end
            if (cfifo_rdreq || rfifo_rdreq) begin
                chk("pop_pair", 64'({cfifo_rdreq, rfifo_rdreq}), 64'd3);
                chk("pop_nonempty", 64'({cfifo_rdempty, rfifo_rdempty}), 64'd0);
            end
            if (mem_write && !mem_waitrequest) begin
                acc_cnt++;
                $display("[TB] write addr=%05h data=%04h", mem_address, mem_writedata);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'({mem_address, mem_writedata}), 64'd0);
                end else begin
                    chk("write", 64'({mem_address, mem_writedata}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = mem_write && mem_waitrequest;
            prev_addr  = mem_address;
            prev_data  = mem_writedata;
        end
    end

    initial begin
        int a0;
        int n;
        reset        = 1'b1;
        sc_cmd       = 5'd0;
        sc_data      = 24'd0;
        sc_switching = 1'b0;
        repeat (3) tick();
        sample();
        chk("rst_write", 64'(mem_write), 64'd0);
        chk("rst_be", 64'(mem_byteenable), 64'd3);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_data", 64'(mem_writedata), 64'd0);
        chk("rst_ready", 64'(sc_ready), 64'd0);
        tick();
        reset = 1'b0;

        // Pass case
        push_vec(4'h0, 24'h000002, 24'hFFFFFF, 24'h000002);
        expect_rec(20'h80000, 16'h8000, 16'h0002);
        wait_drain("pass");
        chk("pass_pops", 64'(cpops), 64'd1);

        // Masked compare, fail then pass
        push_vec(4'h0, 24'h000004, 24'h0000FF, 24'h120006);
        expect_rec(20'h80002, 16'h0012, 16'h0006);
        push_vec(4'h0, 24'h000004, 24'h000004, 24'h120006);
        expect_rec(20'h80004, 16'h8012, 16'h0006);
        wait_drain("mask");

        // Backpressure: three stall cycles per word
        bp_en = 1'b1;
        a0 = acc_cnt;
        push_vec(4'h0, 24'h000ABC, 24'hFFFFFF, 24'h000ABC);
        expect_rec(20'h80006, 16'h8000, 16'h0ABC);
        wait_drain("bp");
        chk("bp_writes", 64'(acc_cnt - a0), 64'd2);
        chk("bp_pops", 64'(rpops), 64'd4);
        bp_en = 1'b0;

        // Ordering and discard with the response FIFO filled late
        cq.push_back({4'h0, 24'h111111, 24'hFFFFFF});
        cq.push_back({4'h1, 24'h000000, 24'hFFFFFF});
        cq.push_back({4'h0, 24'h222222, 24'hFFFFFF});
        repeat (10) tick();
        chk("no_pop_single", 64'(cpops), 64'd4);
        rq.push_back(24'h111111);
        rq.push_back(24'h333333);
        rq.push_back(24'h222223);
        expect_rec(20'h80008, 16'h8011, 16'h1111);
        expect_rec(20'h8000A, 16'h0022, 16'h2223);
        wait_drain("order");
        chk("order_cpops", 64'(cpops), 64'd7);
        chk("order_rpops", 64'(rpops), 64'd7);

        // Drain handshake
        push_vec(4'h0, 24'h00000F, 24'h0000F0, 24'h0000FF);
        expect_rec(20'h8000C, 16'h0000, 16'h00FF);
        push_vec(4'h0, 24'hABCDEF, 24'hFF0000, 24'hAB0000);
        expect_rec(20'h8000E, 16'h80AB, 16'h0000);
        tick();
        tick();
        sc_switching = 1'b1;
        n = 0;
        while (n < 100) begin
            sample();
            if (exp_q.size() == 0) break;
            chk("drain_ready_low", 64'(sc_ready), 64'd0);
            n++;
        end
        chk("drain_in_time", 64'(n < 100), 64'd1);
        sample();
        chk("drain_ready_last", 64'(sc_ready), 64'd0);
        sample();
        chk("drain_ready_rise", 64'(sc_ready), 64'd1);
        tick();
        sc_cmd  = 5'd1;
        sc_data = 24'h000100;
        tick();
        sc_cmd  = 5'd0;
        push_vec(4'h0, 24'h00FF00, 24'h00FF00, 24'h12FF34);
        expect_rec(20'h00100, 16'h8012, 16'hFF34);
        wait_drain("rptr");
        tick();
        sample();
        chk("ready_again", 64'(sc_ready), 64'd1);
        tick();
        sc_switching = 1'b0;
        sample();
        chk("ready_hold", 64'(sc_ready), 64'd1);
        sample();
        chk("ready_drop", 64'(sc_ready), 64'd0);

        // Pointer wrap-around
        tick();
        sc_switching = 1'b1;
        tick();
        tick();
        sc_cmd  = 5'd1;
        sc_data = 24'h0FFFFE;
        tick();
        sc_cmd  = 5'd0;
        push_vec(4'h0, 24'h000000, 24'h000000, 24'hABCDEF);
        expect_rec(20'hFFFFE, 16'h80AB, 16'hCDEF);
        push_vec(4'h0, 24'h000001, 24'h000001, 24'h000000);
        expect_rec(20'h00000, 16'h0000, 16'h0000);
        wait_drain("wrap");
        sc_switching = 1'b0;
        tick();

        // Reset in the middle of a record
        force_wait = 1'b1;
        push_vec(4'h0, 24'h000077, 24'hFFFFFF, 24'h000077);
        n = 0;
        while (!mem_write && n < 20) begin
            sample();
            n++;
        end
        chk("rst_mid_reached", 64'(mem_write), 64'd1);
        chk("rst_mid_addr", 64'(mem_address), 64'h00002);
        tick();
        reset = 1'b1;
        tick();
        sample();
        chk("rst_mid_write", 64'(mem_write), 64'd0);
        tick();
        reset = 1'b0;
        force_wait = 1'b0;
        push_vec(4'h0, 24'h000055, 24'hFFFFFF, 24'h000055);
        expect_rec(20'h80000, 16'h8000, 16'h0055);
        wait_drain("after_reset");

        chk("total_cpops", 64'(cpops), 64'd14);
        chk("total_rpops", 64'(rpops), 64'd14);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
